// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register in front of the ALU. Holds one decoded
// instruction behind a valid/ready handshake and presents it to the ALU as
// operand/control signals. Register operands are bypassed from the MEM and WB
// stages both when the instruction is captured and while it is held waiting
// for the execute stage, so a stalled entry never goes stale. A flush (taken
// branch) empties the stage and drops any instruction offered that cycle.
//
// Parameters
//   XLEN       datapath width
//   REG_AW     register address width
//   BYPASS_EN  1 = MEM/WB bypass active, 0 = register operands pass unmodified
//
// Ports
//   clk, rst_n                     clock (rising edge), synchronous active-low reset
//   id_valid / id_ready            decode-side handshake
//   id_rs1_addr, id_rs2_addr       source register indices
//   id_rs1_data, id_rs2_data       register-file read data
//   id_imm                         sign-extended immediate
//   id_alu_ctrl, id_alu_src        ALU operation and operand-2 select
//   id_rd_addr, id_reg_write       destination register and its write enable
//   flush                          discard held and incoming instruction
//   mem_we, mem_rd, mem_data       MEM-stage bypass source
//   wb_we, wb_rd, wb_data          WB-stage bypass source
//   ex_valid / ex_ready            execute-side handshake
//   ALUop1, RegOp2, ImmOp          ALU operand 1, register operand 2, immediate
//   ALUctrl, ALUsrc                ALU control and operand-2 select
//   ex_rd_addr, ex_reg_write       destination carried forward (write gated by ex_valid)
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [2:0]        id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,

    input  logic              flush,

    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ALUop1,
    output logic [XLEN-1:0]   RegOp2,
    output logic [XLEN-1:0]   ImmOp,
    output logic [2:0]        ALUctrl,
    output logic              ALUsrc,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Held instruction fields.
    logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q;
    logic [XLEN-1:0]   op1_q, op2_q, imm_q;
    logic [2:0]        ctrl_q;
    logic              src_q;
    logic [REG_AW-1:0] rd_q;
    logic              reg_write_q;

    // Handshake decode.
    logic capture;
    logic hold;

    // Bypassed operand values for the incoming and the held instruction.
    logic [XLEN-1:0] cap_op1, cap_op2;
    logic [XLEN-1:0] held_op1, held_op2;

    // Resolve one register operand: x0 reads as zero and is never bypassed;
    // otherwise the youngest producer (MEM) beats WB, which beats the
    // register-file / held value.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   base,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic [XLEN-1:0]   m_data,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd,
        input logic [XLEN-1:0]   w_data
    );
        logic [XLEN-1:0] result;
        result = base;
        if (addr == '0) begin
            result = '0;
        end else if (BYPASS_EN && m_we && (m_rd == addr)) begin
            result = m_data;
        end else if (BYPASS_EN && w_we && (w_rd == addr)) begin
            result = w_data;
        end
        return result;
    endfunction

    always_comb begin
        cap_op1  = resolve(id_rs1_addr, id_rs1_data, mem_we, mem_rd, mem_data,
                           wb_we, wb_rd, wb_data);
        cap_op2  = resolve(id_rs2_addr, id_rs2_data, mem_we, mem_rd, mem_data,
                           wb_we, wb_rd, wb_data);
        held_op1 = resolve(rs1_addr_q, op1_q, mem_we, mem_rd, mem_data,
                           wb_we, wb_rd, wb_data);
        held_op2 = resolve(rs2_addr_q, op2_q, mem_we, mem_rd, mem_data,
                           wb_we, wb_rd, wb_data);
    end

    // Ready does not look at id_valid, so decode can use it without a loop.
    assign ex_valid = (state_q == FULL);
    assign id_ready = rst_n & (~ex_valid | ex_ready);
    assign capture  = id_valid & id_ready & ~flush;
    assign hold     = ex_valid & ~ex_ready & ~flush;

    // Next-state logic: flush empties the stage regardless of anything else.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d = FULL;
        end else if (ex_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload register. Every field is cleared on reset because the outputs
    // are required to read zero after reset, not merely be marked invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            src_q       <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (capture) begin
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            op1_q       <= cap_op1;
            op2_q       <= cap_op2;
            imm_q       <= id_imm;
            ctrl_q      <= id_alu_ctrl;
            src_q       <= id_alu_src;
            rd_q        <= id_rd_addr;
            reg_write_q <= id_reg_write;
        end else if (hold) begin
            // A stalled entry keeps refreshing its operands so a producer that
            // retires through MEM/WB during the stall is not missed.
            op1_q <= held_op1;
            op2_q <= held_op2;
        end
    end

    assign ALUop1       = op1_q;
    assign RegOp2       = op2_q;
    assign ImmOp        = imm_q;
    assign ALUctrl      = ctrl_q;
    assign ALUsrc       = src_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = reg_write_q & ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. Two instances share every input: one with
// bypass enabled and one built with BYPASS_EN=0. Stimulus pushes the expected
// ALU-side values of each instruction that will reach execute into a queue;
// a monitor pops and compares whenever the stage hands an instruction to
// execute (ex_valid & ex_ready). Cycle-specific properties (ready, reset
// values, flush) are checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]        id_alu_ctrl;
    logic              id_alu_src, id_reg_write;
    logic              flush;
    logic              mem_we, wb_we;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic [XLEN-1:0]   mem_data, wb_data;
    logic              ex_ready;

    logic              id_ready, ex_valid, ALUsrc, ex_reg_write;
    logic [XLEN-1:0]   ALUop1, RegOp2, ImmOp;
    logic [2:0]        ALUctrl;
    logic [REG_AW-1:0] ex_rd_addr;

    logic              nb_id_ready, nb_ex_valid, nb_ALUsrc, nb_ex_reg_write;
    logic [XLEN-1:0]   nb_ALUop1, nb_RegOp2, nb_ImmOp;
    logic [2:0]        nb_ALUctrl;
    logic [REG_AW-1:0] nb_ex_rd_addr;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .flush(flush),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUop1(ALUop1), .RegOp2(RegOp2), .ImmOp(ImmOp),
        .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(nb_id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .flush(flush),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(nb_ex_valid), .ex_ready(ex_ready),
        .ALUop1(nb_ALUop1), .RegOp2(nb_RegOp2), .ImmOp(nb_ImmOp),
        .ALUctrl(nb_ALUctrl), .ALUsrc(nb_ALUsrc),
        .ex_rd_addr(nb_ex_rd_addr), .ex_reg_write(nb_ex_reg_write)
    );

    typedef struct {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic [2:0]        ctrl;
        logic              src;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic [XLEN-1:0]   nb_op1;
        logic [XLEN-1:0]   nb_op2;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] actual,
                         input logic [XLEN-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: an instruction leaves the stage when ex_valid & ex_ready at
    // the coming edge; sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ALUop1",       ALUop1,              e.op1);
                check("RegOp2",       RegOp2,              e.op2);
                check("ImmOp",        ImmOp,               e.imm);
                check("ALUctrl",      32'(ALUctrl),        32'(e.ctrl));
                check("ALUsrc",       32'(ALUsrc),         32'(e.src));
                check("ex_rd_addr",   32'(ex_rd_addr),     32'(e.rd));
                check("ex_reg_write", 32'(ex_reg_write),   32'(e.rw));
                check("nb_ALUop1",    nb_ALUop1,           e.nb_op1);
                check("nb_RegOp2",    nb_RegOp2,           e.nb_op2);
                check("nb_ex_valid",  32'(nb_ex_valid),    32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [REG_AW-1:0] rs1, input logic [XLEN-1:0] d1,
                         input logic [REG_AW-1:0] rs2, input logic [XLEN-1:0] d2,
                         input logic [XLEN-1:0] imm, input logic [2:0] ctrl,
                         input logic src, input logic [REG_AW-1:0] rd, input logic rw);
        id_valid     = 1'b1;
        id_rs1_addr  = rs1;
        id_rs1_data  = d1;
        id_rs2_addr  = rs2;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_alu_ctrl  = ctrl;
        id_alu_src   = src;
        id_rd_addr   = rd;
        id_reg_write = rw;
    endtask

    // Offer one instruction for one cycle; if push is set it is expected to
    // be captured and later consumed with the given operand values.
    task automatic send(input logic [REG_AW-1:0] rs1, input logic [XLEN-1:0] d1,
                        input logic [REG_AW-1:0] rs2, input logic [XLEN-1:0] d2,
                        input logic [XLEN-1:0] imm, input logic [2:0] ctrl,
                        input logic src, input logic [REG_AW-1:0] rd, input logic rw,
                        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                        input logic [XLEN-1:0] n1, input logic [XLEN-1:0] n2,
                        input bit push);
        exp_t e;
        drive(rs1, d1, rs2, d2, imm, ctrl, src, rd, rw);
        if (push) begin
            e.op1 = e1;  e.op2 = e2;  e.imm = imm;  e.ctrl = ctrl;
            e.src = src; e.rd = rd;   e.rw = rw;    e.nb_op1 = n1;  e.nb_op2 = n2;
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic idle();
        id_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alu_ctrl = '0; id_alu_src = 1'b0; id_reg_write = 1'b0;
        flush = 1'b0;
        mem_we = 1'b0; mem_rd = '0; mem_data = '0;
        wb_we = 1'b0;  wb_rd = '0;  wb_data = '0;
        ex_ready = 1'b1;

        // Reset state.
        step();
        step();
        check("rst_id_ready",  32'(id_ready),     32'd0);
        check("rst_ex_valid",  32'(ex_valid),     32'd0);
        check("rst_ALUop1",    ALUop1,            32'd0);
        check("rst_ex_rw",     32'(ex_reg_write), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_id_ready", 32'(id_ready), 32'd1);

        // 1: basic capture with one-cycle latency.
        send(5'd3, 32'd5, 5'd4, 32'd7, 32'h100, 3'b000, 1'b0, 5'd1, 1'b1,
             32'd5, 32'd7, 32'd5, 32'd7, 1'b1);
        check("t1_ex_valid", 32'(ex_valid), 32'd1);
        idle();

        // 2: MEM beats WB on the same register; x0 never bypassed; WB-only match.
        mem_we = 1'b1; mem_rd = 5'd6; mem_data = 32'h10;
        wb_we  = 1'b1; wb_rd  = 5'd6; wb_data  = 32'h20;
        send(5'd6, 32'h99, 5'd5, 32'h33, 32'h4, 3'b001, 1'b0, 5'd2, 1'b1,
             32'h10, 32'h33, 32'h99, 32'h33, 1'b1);
        mem_rd = 5'd0;
        wb_rd  = 5'd9;
        send(5'd0, 32'h77, 5'd9, 32'h44, 32'h8, 3'b010, 1'b1, 5'd3, 1'b0,
             32'h0, 32'h20, 32'h0, 32'h44, 1'b1);
        mem_we = 1'b0; wb_we = 1'b0; mem_rd = '0; wb_rd = '0;
        idle();

        // 3: hold for three cycles, WB bypass refreshes the held operand.
        ex_ready = 1'b0;
        send(5'd2, 32'h11, 5'd8, 32'h22, 32'h5, 3'b010, 1'b1, 5'd7, 1'b1,
             32'h11, 32'hAB, 32'h11, 32'h22, 1'b1);
        drive(5'd13, 32'hDEAD, 5'd14, 32'hBEEF, 32'h9, 3'b011, 1'b0, 5'd15, 1'b1);
        #1;
        check("t3_id_ready_c1", 32'(id_ready), 32'd0);
        step();
        wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'hAB;
        #1;
        check("t3_id_ready_c2", 32'(id_ready), 32'd0);
        step();
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        #1;
        check("t3_id_ready_c3", 32'(id_ready), 32'd0);
        check("t3_RegOp2",      RegOp2,        32'hAB);
        check("t3_ALUop1",      ALUop1,        32'h11);
        check("t3_ImmOp",       ImmOp,         32'h5);
        check("t3_rd",          32'(ex_rd_addr), 32'd7);
        check("t3_nb_RegOp2",   nb_RegOp2,     32'h22);
        step();
        ex_ready = 1'b1;
        idle();

        // 4: back-to-back, one per cycle.
        send(5'd1, 32'h100, 5'd2, 32'h200, 32'hFFFF_FFF0, 3'b000, 1'b1, 5'd3, 1'b1,
             32'h100, 32'h200, 32'h100, 32'h200, 1'b1);
        check("t4_valid0", 32'(ex_valid), 32'd1);
        send(5'd4, 32'h1, 5'd5, 32'h2, 32'h7, 3'b001, 1'b0, 5'd4, 1'b0,
             32'h1, 32'h2, 32'h1, 32'h2, 1'b1);
        check("t4_valid1", 32'(ex_valid), 32'd1);
        send(5'd6, 32'hF0F0, 5'd7, 32'h0F0F, 32'h0, 3'b011, 1'b0, 5'd5, 1'b1,
             32'hF0F0, 32'h0F0F, 32'hF0F0, 32'h0F0F, 1'b1);
        check("t4_valid2", 32'(ex_valid), 32'd1);
        send(5'd9, 32'h8000_0000, 5'd10, 32'h1, 32'h10, 3'b101, 1'b1, 5'd31, 1'b1,
             32'h8000_0000, 32'h1, 32'h8000_0000, 32'h1, 1'b1);
        check("t4_valid3", 32'(ex_valid), 32'd1);
        idle();
        check("t4_drain_valid", 32'(ex_valid), 32'd0);

        // 5: flush while held with a new instruction offered.
        ex_ready = 1'b0;
        send(5'd11, 32'h55, 5'd12, 32'h66, 32'h1, 3'b000, 1'b0, 5'd6, 1'b1,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t5_held_rw", 32'(ex_reg_write), 32'd1);
        flush = 1'b1;
        send(5'd13, 32'h77, 5'd14, 32'h88, 32'h2, 3'b001, 1'b1, 5'd9, 1'b1,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        check("t5_ex_valid", 32'(ex_valid),     32'd0);
        check("t5_ex_rw",    32'(ex_reg_write), 32'd0);
        ex_ready = 1'b1;
        idle();
        check("t5_no_capture", 32'(ex_valid), 32'd0);

        // 6: reset in the middle of a hold.
        ex_ready = 1'b0;
        send(5'd3, 32'h123, 5'd4, 32'h456, 32'h789, 3'b101, 1'b1, 5'd10, 1'b1,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("t6_id_ready_rst", 32'(id_ready), 32'd0);
        step();
        check("t6_ex_valid", 32'(ex_valid),     32'd0);
        check("t6_ALUop1",   ALUop1,            32'd0);
        check("t6_RegOp2",   RegOp2,            32'd0);
        check("t6_ImmOp",    ImmOp,             32'd0);
        check("t6_ctrl",     32'(ALUctrl),      32'd0);
        check("t6_src",      32'(ALUsrc),       32'd0);
        check("t6_rd",       32'(ex_rd_addr),   32'd0);
        check("t6_rw",       32'(ex_reg_write), 32'd0);
        rst_n = 1'b1;
        ex_ready = 1'b1;

        // Recovery after reset, MEM bypass on operand 2 only.
        mem_we = 1'b1; mem_rd = 5'd12; mem_data = 32'hCAFE;
        send(5'd11, 32'h31, 5'd12, 32'h32, 32'h3, 3'b011, 1'b0, 5'd12, 1'b1,
             32'h31, 32'hCAFE, 32'h31, 32'h32, 1'b1);
        mem_we = 1'b0; mem_rd = '0; mem_data = '0;
        idle();
        idle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
